tty_char_writer: RTL
====================

// Module: tty_char_writer
// PURPOSE
//  Glass-TTY front end for the text-mode display. Accepts an ASCII byte stream on a
//  valid/ready handshake and drives port B (clk_data side) of the text-buffer dualmem,
//  whose port A is scanned by the display driver. Handles cursor, CR/LF/BS/TAB/FF,
//  line wrap and hardware scroll (row copy via port B reads). Lets software print without
//  per-character address arithmetic.
// PARAMETERS
//  COL_BITS   7      column index width; COLS = 2**COL_BITS (128)
//  ROW_BITS   6      row index width; ROWS = 2**ROW_BITS (64); addrb = {row,col}
//  FILL_CHAR  8'h20  byte written by clear and scroll-fill
// PORTS
//  clk_data    in   1          sole clock; same clock as dualmem port B
//  irst        in   1          synchronous active-high reset
//  char_valid  in   1          byte offered
//  char_data   in   8          ASCII byte
//  char_ready  out  1          byte accepted when char_valid & char_ready
//  addrb       out  13         text RAM address {row[5:0],col[6:0]}
//  dinb        out  8          text RAM write data
//  web         out  1          text RAM write enable
//  enb         out  1          text RAM enable (read or write)
//  doutb       in   8          text RAM read data, valid 1 cycle after enb & !web
//  cur_row     out  ROW_BITS   cursor row
//  cur_col     out  COL_BITS   cursor column
//  busy        out  1          high in any state but IDLE
// BEHAVIOUR
//  Reset: cur_row=0, cur_col=0, web=0, enb=0, addrb=0, dinb=0, char_ready=0, busy=1;
//   state<=CLEAR_ALL. irst mid-anything aborts, no partial write after irst cycle.
//  States: CLEAR_ALL, IDLE, PUT, SCR_RD, SCR_WR, SCR_FILL.
//  CLEAR_ALL: one write/cycle of FILL_CHAR, addr 0..ROWS*COLS-1 (8192 cycles), then IDLE
//   with cursor (0,0). Also entered on FF (0x0C).
//  IDLE: char_ready=1 only here; enb=web=0. Accept at cycle N, decode:
//   0x20-0x7E: PUT; cycle N+1 web=enb=1, addrb={row,col}, dinb=byte; then advance.
//   0x0D CR: col<=0. 0x0A LF: col<=0, newline. 0x08 BS: col<=col-1 if col>0, no write.
//   0x09 TAB: col<=(col|7)+1; if col>=COLS-8, newline instead.
//   Other bytes (ctrl, 0x7F, >=0x80): consumed, no effect. Non-writing codes: ready N+1.
//  Advance after PUT: col<COLS-1 -> col+1; col==COLS-1 -> col<=0, newline.
//  Newline: row<ROWS-1 -> row+1, back to IDLE; row==ROWS-1 -> row unchanged, SCROLL.
//  SCROLL, per dest addr d = row r (0..ROWS-2), col c, ascending c then r:
//   SCR_RD: enb=1, web=0, addrb={r+1,c}; SCR_WR next cycle: enb=web=1, addrb={r,c},
//   dinb=doutb. 2 cycles/byte, not pipelined.
//   SCR_FILL: row ROWS-1 all COLS written FILL_CHAR, 1/cycle.
//   Total scroll = 2*COLS*(ROWS-1)+COLS = 16256 cycles; then IDLE, cursor (ROWS-1,0).
//  Cursor wraps only as above; never out of range. Regs cur_row/cur_col update
//   same edge state leaves PUT/decode. char_valid ignored while char_ready=0.
// TESTING
//  T1 irst 1 cycle -> 8192 consecutive writes of 0x20 addr 0..8191, then char_ready=1.
//  T2 send "AB" at (0,0) -> writes addr 0x0000=0x41, 0x0001=0x42; cursor (0,2).
//  T3 cursor (3,127), send 'Z' -> write addr {3,127}=0x5A; cursor (4,0).
//  T4 cursor (5,10): 0x09 -> col 16; 0x08 -> col 15; 0x0D -> col 0; no web pulses.
//  T5 rows preloaded row-number, cursor (63,0), send 0x0A -> row r holds r+1 for
//   r<63, row 63 all 0x20; busy exactly 16256 cycles; cursor (63,0).
//  T6 irst asserted mid-scroll -> web low next cycle, CLEAR_ALL restarts at addr 0.

Source files
------------

// File: rtl/tty_char_writer.sv
// Glass-TTY writer: byte stream in, text-RAM port B out; printable bytes write one cycle after accept.
// char_ready is high only in IDLE, so clear, scroll and the write cycle of a printable byte all backpressure.
module tty_char_writer #(
    parameter int         COL_BITS  = 7,
    parameter int         ROW_BITS  = 6,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                         clk_data,
    input  logic                         irst,
    input  logic                         char_valid,
    input  logic [7:0]                   char_data,
    output logic                         char_ready,
    output logic [ROW_BITS+COL_BITS-1:0] addrb,
    output logic [7:0]                   dinb,
    output logic                         web,
    output logic                         enb,
    input  logic [7:0]                   doutb,
    output logic [ROW_BITS-1:0]          cur_row,
    output logic [COL_BITS-1:0]          cur_col,
    output logic                         busy
);
    localparam int AW = ROW_BITS + COL_BITS;

    localparam logic [2:0] S_CLEAR    = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_PUT      = 3'd2;
    localparam logic [2:0] S_SCR_RD   = 3'd3;
    localparam logic [2:0] S_SCR_WR   = 3'd4;
    localparam logic [2:0] S_SCR_FILL = 3'd5;

    localparam logic [COL_BITS-1:0] COL_MAX  = '1;
    localparam logic [ROW_BITS-1:0] ROW_MAX  = '1;
    localparam logic [ROW_BITS-1:0] LAST_DST = ROW_MAX - ROW_BITS'(1);
    localparam logic [COL_BITS-1:0] TAB_LIM  = COL_MAX - COL_BITS'(7);

    logic [2:0]          state;
    logic [AW:0]         clr_cnt;
    logic [ROW_BITS-1:0] scr_row;
    logic [COL_BITS-1:0] scr_col;
    logic [7:0]          dinb_q;

    logic                accept, is_print, tab_wrap, do_newline, at_last_row;
    logic                scr_last_col, scr_done;
    logic [ROW_BITS-1:0] nxt_row, src_row;
    logic [COL_BITS-1:0] nxt_col;

    always_comb begin
        accept       = (state == S_IDLE) && char_valid;
        is_print     = (char_data >= 8'h20) && (char_data <= 8'h7E);
        tab_wrap     = cur_col >= TAB_LIM;
        at_last_row  = cur_row == ROW_MAX;
        do_newline   = (accept && ((char_data == 8'h0A) || ((char_data == 8'h09) && tab_wrap)))
                     || ((state == S_PUT) && (cur_col == COL_MAX));
        scr_last_col = scr_col == COL_MAX;
        scr_done     = scr_last_col && (scr_row == LAST_DST);
        nxt_row      = scr_last_col ? scr_row + ROW_BITS'(1) : scr_row;
        nxt_col      = scr_col + COL_BITS'(1);
        src_row      = nxt_row + ROW_BITS'(1);
        char_ready   = state == S_IDLE;
        busy         = state != S_IDLE;
        // scroll writes forward the RAM read data issued in the preceding SCR_RD cycle
        dinb         = (state == S_SCR_WR) ? doutb : dinb_q;
    end

    always_ff @(posedge clk_data) begin
        if (irst) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            cur_row <= '0;
            cur_col <= '0;
            scr_row <= '0;
            scr_col <= '0;
            web     <= 1'b0;
            enb     <= 1'b0;
            addrb   <= '0;
            dinb_q  <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_cnt[AW]) begin
                        state <= S_IDLE;
                        web   <= 1'b0;
                        enb   <= 1'b0;
                    end else begin
                        web     <= 1'b1;
                        enb     <= 1'b1;
                        addrb   <= clr_cnt[AW-1:0];
                        dinb_q  <= FILL_CHAR;
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (accept) begin
                        if (is_print) begin
                            state  <= S_PUT;
                            web    <= 1'b1;
                            enb    <= 1'b1;
                            addrb  <= {cur_row, cur_col};
                            dinb_q <= char_data;
                        end else begin
                            case (char_data)
                                8'h0D, 8'h0A: cur_col <= '0;
                                8'h08: if (cur_col != '0) cur_col <= cur_col - COL_BITS'(1);
                                8'h09: cur_col <= tab_wrap ? '0 : (cur_col | COL_BITS'(7)) + COL_BITS'(1);
                                8'h0C: begin
                                    state   <= S_CLEAR;
                                    clr_cnt <= '0;
                                    cur_row <= '0;
                                    cur_col <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_PUT: begin
                    state   <= S_IDLE;
                    web     <= 1'b0;
                    enb     <= 1'b0;
                    cur_col <= cur_col + COL_BITS'(1);
                end
                S_SCR_RD: begin
                    state <= S_SCR_WR;
                    web   <= 1'b1;
                    enb   <= 1'b1;
                    addrb <= {scr_row, scr_col};
                end
                S_SCR_WR: begin
                    if (scr_done) begin
                        state   <= S_SCR_FILL;
                        scr_col <= '0;
                        web     <= 1'b1;
                        enb     <= 1'b1;
                        addrb   <= {ROW_MAX, {COL_BITS{1'b0}}};
                        dinb_q  <= FILL_CHAR;
                    end else begin
                        state   <= S_SCR_RD;
                        web     <= 1'b0;
                        enb     <= 1'b1;
                        scr_row <= nxt_row;
                        scr_col <= nxt_col;
                        addrb   <= {src_row, nxt_col};
                    end
                end
                S_SCR_FILL: begin
                    if (scr_last_col) begin
                        state <= S_IDLE;
                        web   <= 1'b0;
                        enb   <= 1'b0;
                    end else begin
                        scr_col <= nxt_col;
                        addrb   <= {ROW_MAX, nxt_col};
                    end
                end
                default: begin
                    state   <= S_CLEAR;
                    clr_cnt <= '0;
                end
            endcase

            // newline overrides the case above: either step down a row or start the scroll
            if (do_newline) begin
                if (!at_last_row) begin
                    cur_row <= cur_row + ROW_BITS'(1);
                end else begin
                    state   <= S_SCR_RD;
                    scr_row <= '0;
                    scr_col <= '0;
                    web     <= 1'b0;
                    enb     <= 1'b1;
                    addrb   <= {ROW_BITS'(1), {COL_BITS{1'b0}}};
                end
            end
        end
    end
endmodule
